// File: rtl/temporal_ngram_encoder.sv
// temporal_ngram_encoder
//   Binds the last NGRAM_SIZE spatial hypervectors into one temporal N-gram:
//   NG = x(t) ^ rho(x(t-1)) ^ ... ^ rho^(N-1)(x(t-N+1)), where rho rotates right by 1
//   (bit k takes bit k-1; bit 0 takes bit HV_DIMENSION-1). A change of mode or label
//   restarts the window. The result is held in a one-entry output register with
//   valid/ready on both sides.
// Ports:
//   Clk_CI, Reset_RI                 clock, synchronous active-high reset
//   ValidIn_SI / ReadyOut_SO         upstream handshake
//   ModeIn_SI, LabelIn_DI            per-sample mode / label
//   HypervectorIn_DI                 spatial hypervector, bit 0 leftmost
//   ValidOut_SO / ReadyIn_SI         downstream handshake
//   ModeOut_SO, LabelOut_DO          mode / label attached to the N-gram
//   NGramOut_DO                      N-gram hypervector
module temporal_ngram_encoder #(
  parameter int HV_DIMENSION = 2000,
  parameter int NGRAM_SIZE   = 3,
  parameter int MODE_WIDTH   = 1,
  parameter int LABEL_WIDTH  = 3
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]   ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]   ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
  output logic [0:HV_DIMENSION-1] NGramOut_DO
);

  // Keep at least one history slot / one counter bit so NGRAM_SIZE=1 still elaborates;
  // in that case the history is never read and the counter stays at 0.
  localparam int HIST = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
  localparam int CW   = (NGRAM_SIZE > 1) ? $clog2(NGRAM_SIZE) : 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(NGRAM_SIZE - 1);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            fill_q, fill_d;
  logic [0:HV_DIMENSION-1]  hist_q [0:HIST-1];
  logic [MODE_WIDTH-1:0]    mode_q;
  logic [LABEL_WIDTH-1:0]   label_q;
  logic [0:HV_DIMENSION-1]  ng_q, ng_d;
  logic [MODE_WIDTH-1:0]    mode_out_q;
  logic [LABEL_WIDTH-1:0]   label_out_q;

  logic accept, win_break, emit;

  assign accept    = ValidIn_SI && ReadyOut_SO;
  assign win_break = accept && (fill_q != '0) &&
                     ((ModeIn_SI != mode_q) || (LabelIn_DI != label_q));
  assign emit      = accept && !win_break && (fill_q == FILL_MAX);

  // XOR of the input with the rotated history; hist[i] is rotated i+1 times.
  always_comb begin
    ng_d = HypervectorIn_DI;
    for (int i = 0; i < NGRAM_SIZE - 1; i++) begin
      for (int k = 0; k < HV_DIMENSION; k++) begin
        ng_d[k] = ng_d[k] ^ hist_q[i][(k + 8 * HV_DIMENSION - 1 - i) % HV_DIMENSION];
      end
    end
  end

  // Fill counter: restarts at 1 on a window break (the new sample is the first of
  // the new window), otherwise saturates at NGRAM_SIZE-1.
  always_comb begin
    fill_d = fill_q;
    if (accept) begin
      if (win_break)              fill_d = CW'(1);
      else if (fill_q != FILL_MAX) fill_d = fill_q + CW'(1);
    end
  end

  // Output FSM. In FULL, input is only taken when downstream drains the register in
  // the same cycle, so a pending N-gram is never overwritten.
  always_comb begin
    state_d     = state_q;
    ReadyOut_SO = !Reset_RI && ((state_q == EMPTY) || ReadyIn_SI);
    ValidOut_SO = (state_q == FULL);
    case (state_q)
      EMPTY: if (emit) state_d = FULL;
      FULL:  if (ReadyIn_SI) state_d = emit ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q     <= EMPTY;
      fill_q      <= '0;
      mode_q      <= '0;
      label_q     <= '0;
      ng_q        <= '0;
      mode_out_q  <= '0;
      label_out_q <= '0;
      for (int i = 0; i < HIST; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (accept) begin
        hist_q[0] <= HypervectorIn_DI;
        for (int i = 1; i < HIST; i++) hist_q[i] <= hist_q[i-1];
        mode_q  <= ModeIn_SI;
        label_q <= LabelIn_DI;
      end
      if (emit) begin
        ng_q        <= ng_d;
        mode_out_q  <= ModeIn_SI;
        label_out_q <= LabelIn_DI;
      end
    end
  end

  assign NGramOut_DO = ng_q;
  assign ModeOut_SO  = mode_out_q;
  assign LabelOut_DO = label_out_q;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed bench: three instances (NGRAM_SIZE 3, 1, 2) with HV_DIMENSION=8 share the
// input stimulus; each section checks the instance it targets.
module tb_temporal_ngram_encoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       vin;
  logic [0:0] mode;
  logic [2:0] lab;
  logic [0:7] hv;
  logic       rdy_in;

  logic       rdy3, vld3, rdy1, vld1, rdy2, vld2;
  logic [0:0] mo3, mo1, mo2;
  logic [2:0] lo3, lo1, lo2;
  logic [0:7] ng3, ng1, ng2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3), .MODE_WIDTH(1), .LABEL_WIDTH(3)) u3 (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy3),
    .ModeIn_SI(mode), .LabelIn_DI(lab), .HypervectorIn_DI(hv),
    .ValidOut_SO(vld3), .ReadyIn_SI(rdy_in), .ModeOut_SO(mo3), .LabelOut_DO(lo3), .NGramOut_DO(ng3));

  temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(1), .MODE_WIDTH(1), .LABEL_WIDTH(3)) u1 (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy1),
    .ModeIn_SI(mode), .LabelIn_DI(lab), .HypervectorIn_DI(hv),
    .ValidOut_SO(vld1), .ReadyIn_SI(rdy_in), .ModeOut_SO(mo1), .LabelOut_DO(lo1), .NGramOut_DO(ng1));

  temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(2), .MODE_WIDTH(1), .LABEL_WIDTH(3)) u2 (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy2),
    .ModeIn_SI(mode), .LabelIn_DI(lab), .HypervectorIn_DI(hv),
    .ValidOut_SO(vld2), .ReadyIn_SI(rdy_in), .ModeOut_SO(mo2), .LabelOut_DO(lo2), .NGramOut_DO(ng2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic [2:0] l);
    vin = v; hv = d; lab = l;
  endtask

  task automatic do_reset;
    cyc; rst = 1'b1; vin = 1'b0;
    #1 chk("rst_ready_low", 32'(rdy3), 32'd0);
    cyc; rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mode = '0; rdy_in = 1'b1;
    drv(1'b1, 8'hFF, 3'd2);              // presented during reset: must be dropped
    cyc; cyc;
    chk("reset_vld", 32'(vld3), 32'd0);
    chk("reset_ng", 32'(ng3), 32'd0);
    chk("reset_rdy", 32'(rdy3), 32'd0);
    rst = 1'b0; vin = 1'b0;
    #1 chk("post_reset_rdy", 32'(rdy3), 32'd1);

    // Test 1: window fill and rotate
    cyc; drv(1'b1, 8'b10000000, 3'd2);
    cyc; chk("t1_no_out_A", 32'(vld3), 32'd0); drv(1'b1, 8'b11000000, 3'd2);
    cyc; chk("t1_no_out_B", 32'(vld3), 32'd0); drv(1'b1, 8'b00000001, 3'd2);
    cyc; chk("t1_vld_C", 32'(vld3), 32'd1);
    chk("t1_ng_C", 32'(ng3), 32'b01000001);
    chk("t1_lab_C", 32'(lo3), 32'd2);
    drv(1'b1, 8'b00000000, 3'd2);
    cyc; chk("t1_vld_D", 32'(vld3), 32'd1);
    chk("t1_ng_D", 32'(ng3), 32'b10110000);
    drv(1'b0, 8'h00, 3'd2);
    cyc; chk("t1_drain", 32'(vld3), 32'd0);

    // Test 2: label change breaks the window
    do_reset;
    cyc; drv(1'b1, 8'b10000000, 3'd2);
    cyc; drv(1'b1, 8'b11000000, 3'd2);
    cyc; drv(1'b1, 8'b00000001, 3'd5);   // C, label 5: break
    cyc; chk("t2_no_out_C", 32'(vld3), 32'd0); drv(1'b1, 8'b00100100, 3'd5);
    cyc; chk("t2_no_out_E", 32'(vld3), 32'd0); drv(1'b1, 8'b11110000, 3'd5);
    cyc; chk("t2_vld_F", 32'(vld3), 32'd1);
    chk("t2_ng_F", 32'(ng3), 32'b10100010);
    chk("t2_lab_F", 32'(lo3), 32'd5);

    // Test 3: backpressure with G pending
    rdy_in = 1'b0; drv(1'b1, 8'b00000011, 3'd5);
    #1 chk("t3_rdy_low", 32'(rdy3), 32'd0);
    for (int c = 0; c < 4; c++) begin
      cyc;
      chk("t3_hold_vld", 32'(vld3), 32'd1);
      chk("t3_hold_ng", 32'(ng3), 32'b10100010);
      chk("t3_hold_lab", 32'(lo3), 32'd5);
      chk("t3_hold_rdy", 32'(rdy3), 32'd0);
    end
    rdy_in = 1'b1;
    #1 chk("t3_rdy_release", 32'(rdy3), 32'd1);
    cyc; chk("t3_vld_G", 32'(vld3), 32'd1);
    chk("t3_ng_G", 32'(ng3), 32'b01110010);

    // Test 5: reset while FULL with a full window; the sample held is dropped
    rst = 1'b1; drv(1'b1, 8'hFF, 3'd5);
    cyc; chk("t5_vld", 32'(vld3), 32'd0);
    chk("t5_ng", 32'(ng3), 32'd0);
    chk("t5_rdy_in_reset", 32'(rdy3), 32'd0);
    rst = 1'b0; drv(1'b1, 8'b10000000, 3'd2);
    #1 chk("t5_rdy_after", 32'(rdy3), 32'd1);
    cyc; chk("t5_no_out_A", 32'(vld3), 32'd0); drv(1'b1, 8'b11000000, 3'd2);
    cyc; chk("t5_no_out_B", 32'(vld3), 32'd0); drv(1'b1, 8'b00000001, 3'd2);
    cyc; chk("t5_vld_C", 32'(vld3), 32'd1);
    chk("t5_ng_C", 32'(ng3), 32'b01000001);
    drv(1'b0, 8'h00, 3'd2);

    // Test 4: NGRAM_SIZE=1 passes every sample through
    do_reset;
    cyc; drv(1'b1, 8'b10101010, 3'd0);
    cyc; chk("t4_vld_1", 32'(vld1), 32'd1);
    chk("t4_ng_1", 32'(ng1), 32'b10101010);
    drv(1'b1, 8'b01010101, 3'd0);
    cyc; chk("t4_vld_2", 32'(vld1), 32'd1);
    chk("t4_ng_2", 32'(ng1), 32'b01010101);
    drv(1'b0, 8'h00, 3'd0);

    // Test 6: rotate wrap with NGRAM_SIZE=2
    do_reset;
    cyc; drv(1'b1, 8'b00000001, 3'd0);
    cyc; chk("t6_no_out", 32'(vld2), 32'd0); drv(1'b1, 8'b00000000, 3'd0);
    cyc; chk("t6_vld", 32'(vld2), 32'd1);
    chk("t6_ng_wrap", 32'(ng2), 32'b10000000);
    drv(1'b0, 8'h00, 3'd0);
    cyc; chk("t6_drain", 32'(vld2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
- Sits directly downstream of the spatial encoder. Consumes one fused spatial hypervector per sample, with its mode and label.
- Binds the last NGRAM_SIZE samples into a temporal N-gram hypervector: XOR of permuted history.
- Forwards the N-gram, with mode and label, to the associative-memory / training stage over a valid/ready handshake.

Parameters:
- HV_DIMENSION, 2000, hypervector width in bits.
- NGRAM_SIZE, 3, number of samples bound per N-gram. Legal range 1..8.
- MODE_WIDTH, 1, width of the training/inference mode field.
- LABEL_WIDTH, 3, width of the class label field.

Ports:
- Clk_CI  in  1  clock; all state updates on the rising edge.
- Reset_RI  in  1  reset, synchronous, active-high.
- ValidIn_SI  in  1  upstream sample valid.
- ReadyOut_SO  out  1  block can accept a sample this cycle.
- ModeIn_SI  in  MODE_WIDTH  mode of the incoming sample.
- LabelIn_DI  in  LABEL_WIDTH  label of the incoming sample.
- HypervectorIn_DI  in  [0:HV_DIMENSION-1]  spatial hypervector; bit 0 is the leftmost bit.
- ValidOut_SO  out  1  N-gram output valid.
- ReadyIn_SI  in  1  downstream accepts the output.
- ModeOut_SO  out  MODE_WIDTH  mode attached to the N-gram.
- LabelOut_DO  out  LABEL_WIDTH  label attached to the N-gram.
- NGramOut_DO  out  [0:HV_DIMENSION-1]  N-gram hypervector.

Behaviour:
- Permutation rho is a right rotate by 1 bit: rho(x)[k] = x[k-1] for k>0; rho(x)[0] = x[HV_DIMENSION-1]. rho^j is j rotations.
- History registers hist[0..NGRAM_SIZE-2] hold the previously accepted vectors; hist[0] is the newest.
- Per-sample mode and label are stored alongside the history.
- Fill counter FillCnt_SP saturates at NGRAM_SIZE-1.
- Accept condition: ValidIn_SI && ReadyOut_SO.
- N-gram value: NG = HypervectorIn_DI XOR rho^1(hist[0]) XOR ... XOR rho^(N-1)(hist[N-2]). Pure XOR, no carries or width growth. For NGRAM_SIZE=1, NG = HypervectorIn_DI, so every sample is emitted.
- Window break: on accept, if FillCnt_SP>0 and (ModeIn_SI != stored mode or LabelIn_DI != stored label), the history is treated as empty. FillCnt restarts at 1 with the new vector in hist[0], and no output is produced.
- On accept, all cases:
  - hist shifts: hist[0] <= input, hist[i] <= hist[i-1].
  - Stored mode and label update to the input values.
- Emit condition: accept with no window break and FillCnt_SP == NGRAM_SIZE-1.
  - Output register loads NG, ModeIn_SI and LabelIn_DI.
  - Latency is 1 cycle: ValidOut_SO rises the cycle after the accept.
- No-emit accepts (window filling): FillCnt increments, output register is untouched, and there is no stall.
- Two-state output FSM:
  - EMPTY: ValidOut_SO=0, ReadyOut_SO=1. An emitting accept moves to FULL; any other accept stays in EMPTY.
  - FULL: ValidOut_SO=1. ReadyOut_SO = ReadyIn_SI, so in-flight data is never overwritten.
  - FULL with ReadyIn_SI=1 and an emitting accept: output register reloads in the same cycle, stays FULL (back-to-back, one N-gram per cycle).
  - FULL with ReadyIn_SI=1 and no emitting accept: go to EMPTY.
  - FULL with ReadyIn_SI=0: hold NGramOut_DO, ModeOut_SO and LabelOut_DO stable; no input accepted.
- Reset (any cycle, including mid-window or while FULL):
  - FSM goes to EMPTY, FillCnt=0, hist and stored mode/label cleared to 0.
  - Output register cleared to 0; ValidOut_SO=0.
  - ReadyOut_SO=0 while Reset_RI is high, 1 on the first cycle after.
  - A sample presented during reset is dropped.
- ValidIn_SI high with ReadyOut_SO low: nothing happens; upstream must hold its data.

Test Plan:
Test 1, window fill and rotate (HV_DIMENSION=8, NGRAM_SIZE=3, label 2 throughout):
- Inputs A=10000000, B=11000000, C=00000001, D=00000000 on consecutive cycles, ReadyIn_SI=1.
- No output after A or B.
- The cycle after C: ValidOut_SO=1, NGramOut=01000001.
- The cycle after D: NGramOut=10110000, ValidOut_SO held at 1.

Test 2, label change breaks the window:
- A, B with label 2, then C with label 5.
- No output. FillCnt=1, hist[0]=C.
- Two further label-5 samples E, F are needed; the output appears only after F and equals F ^ rho(E) ^ rho^2(C), with LabelOut_DO=5.

Test 3, backpressure:
- After the first N-gram, hold ReadyIn_SI=0 for 4 cycles with ValidIn_SI=1.
- ReadyOut_SO=0 and the outputs stay stable for those cycles; no history shift.
- Release ReadyIn_SI: the pending input is accepted, and the next N-gram appears 1 cycle later.

Test 4, NGRAM_SIZE=1:
- Inputs 10101010 then 01010101.
- Each is emitted unchanged 1 cycle after its accept.

Test 5, reset mid-operation:
- Assert Reset_RI after A, B (FillCnt=2) while FULL.
- Next cycle: ValidOut_SO=0, NGramOut=0.
- Afterwards the first output requires 3 new inputs.

Test 6, rotate wrap:
- HV_DIMENSION=8, NGRAM_SIZE=2, inputs 00000001 then 00000000.
- Output 10000000: bit 7 of the older vector wraps to bit 0.
